// File: rtl/ram_2w2r_xor.sv
`default_nettype none
// ============================================================================
//  Module   : ram_2w2r_xor_copy / ram_2w2r_xor
//  Purpose  : Two-write / two-read RAM built from XOR-banked 1R1W copies.
//             Bank A is written only by write port A and bank B only by
//             write port B. The logical word is bankA ^ bankB. A synchronous
//             clear sequence zeroes every copy after reset or a flush pulse.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  One simple-dual-port copy: one write port and one registered read port.
//  A read of an address being written in the same cycle returns the old word.
// ----------------------------------------------------------------------------
module ram_2w2r_xor_copy #(
    parameter int WIDTH  = 1,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);
    localparam int DEPTH = 2**ADDR_W;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port plus registered read port, the shape block RAM inference expects.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// ----------------------------------------------------------------------------
//  Top level
// ----------------------------------------------------------------------------
module ram_2w2r_xor #(
    parameter int WIDTH  = 1,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              W_en_A,
    input  logic              W_en_B,
    input  logic [ADDR_W-1:0] W_addr_A,
    input  logic [ADDR_W-1:0] W_addr_B,
    input  logic [WIDTH-1:0]  W_data_A,
    input  logic [WIDTH-1:0]  W_data_B,
    input  logic              R_en_A,
    input  logic              R_en_B,
    input  logic [ADDR_W-1:0] R_addr_A,
    input  logic [ADDR_W-1:0] R_addr_B,
    output logic [WIDTH-1:0]  R_data_A,
    output logic [WIDTH-1:0]  R_data_B,
    output logic              R_valid_A,
    output logic              R_valid_B,
    input  logic              flush,
    output logic              busy
);
    localparam int                DEPTH       = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] w_clr_addr_nxt;

    // ------------------------------------------------------------------
    //  Clear sequencer
    // ------------------------------------------------------------------

    // State register; reset parks the counter at address 0 inside CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // Next state: flush only starts a clear from IDLE, so a flush while busy is ignored.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    w_state_nxt    = ST_CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
            ST_CLEAR: begin
                if (r_clr_addr == c_LAST_ADDR) begin
                    w_state_nxt    = ST_IDLE;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = ST_CLEAR;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    logic w_clear_we;
    logic w_accept;
    logic w_commit_ok;

    assign busy        = (r_state == ST_CLEAR);
    assign w_clear_we  = (r_state == ST_CLEAR) && !rst;
    // Requests in the cycle that launches a clear are dropped so none can
    // land while busy is high.
    assign w_accept    = (r_state == ST_IDLE) && !flush && !rst;
    assign w_commit_ok = (r_state == ST_IDLE) && !rst;

    // ------------------------------------------------------------------
    //  Write pipeline: stage 1 looks up the other bank, stage 2 commits
    // ------------------------------------------------------------------
    logic w_wr_A;
    logic w_wr_B;
    logic w_rd_A;
    logic w_rd_B;

    assign w_wr_A = w_accept && W_en_A;
    // Port A wins a same-address collision; port B's write is dropped.
    assign w_wr_B = w_accept && W_en_B && !(W_en_A && (W_addr_A == W_addr_B));
    assign w_rd_A = w_accept && R_en_A;
    assign w_rd_B = w_accept && R_en_B;

    logic              r_s2_en_A;
    logic              r_s2_en_B;
    logic [ADDR_W-1:0] r_s2_addr_A;
    logic [ADDR_W-1:0] r_s2_addr_B;
    logic [WIDTH-1:0]  r_s2_data_A;
    logic [WIDTH-1:0]  r_s2_data_B;
    logic              r_old_hit_A;
    logic              r_old_hit_B;
    logic [WIDTH-1:0]  r_old_val_A;
    logic [WIDTH-1:0]  r_old_val_B;
    logic [WIDTH-1:0]  w_old_mem_A;
    logic [WIDTH-1:0]  w_old_mem_B;

    logic              w_cmt_en_A;
    logic              w_cmt_en_B;
    logic [WIDTH-1:0]  w_cmt_val_A;
    logic [WIDTH-1:0]  w_cmt_val_B;

    assign w_cmt_en_A = r_s2_en_A && w_commit_ok;
    assign w_cmt_en_B = r_s2_en_B && w_commit_ok;

    // The other bank's word is the RAM copy, unless the other port committed
    // to that address in the same cycle as the lookup (RAM returned stale data).
    assign w_cmt_val_A = r_s2_data_A ^ (r_old_hit_A ? r_old_val_A : w_old_mem_A);
    assign w_cmt_val_B = r_s2_data_B ^ (r_old_hit_B ? r_old_val_B : w_old_mem_B);

    // Stage-2 valid flags; reset and clear entry abandon pending writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_en_A <= 1'b0;
            r_s2_en_B <= 1'b0;
        end else begin
            r_s2_en_A <= w_wr_A;
            r_s2_en_B <= w_wr_B;
        end
    end

    // Stage-2 datapath and cross-bank forwarding capture.
    always_ff @(posedge clk) begin
        r_s2_addr_A <= W_addr_A;
        r_s2_addr_B <= W_addr_B;
        r_s2_data_A <= W_data_A;
        r_s2_data_B <= W_data_B;
        r_old_hit_A <= w_cmt_en_B && (r_s2_addr_B == W_addr_A);
        r_old_hit_B <= w_cmt_en_A && (r_s2_addr_A == W_addr_B);
        r_old_val_A <= w_cmt_val_B;
        r_old_val_B <= w_cmt_val_A;
    end

    // ------------------------------------------------------------------
    //  Bank write ports (clear has priority; commits are blocked then)
    // ------------------------------------------------------------------
    logic              w_we_A;
    logic              w_we_B;
    logic [ADDR_W-1:0] w_waddr_A;
    logic [ADDR_W-1:0] w_waddr_B;
    logic [WIDTH-1:0]  w_wdata_A;
    logic [WIDTH-1:0]  w_wdata_B;

    assign w_we_A    = w_clear_we || w_cmt_en_A;
    assign w_we_B    = w_clear_we || w_cmt_en_B;
    assign w_waddr_A = w_clear_we ? r_clr_addr : r_s2_addr_A;
    assign w_waddr_B = w_clear_we ? r_clr_addr : r_s2_addr_B;
    assign w_wdata_A = w_clear_we ? '0 : w_cmt_val_A;
    assign w_wdata_B = w_clear_we ? '0 : w_cmt_val_B;

    logic [WIDTH-1:0] w_rd_A_bankA;
    logic [WIDTH-1:0] w_rd_A_bankB;
    logic [WIDTH-1:0] w_rd_B_bankA;
    logic [WIDTH-1:0] w_rd_B_bankB;

    // Bank A copies: lookup for writer B, read port A, read port B.
    ram_2w2r_xor_copy #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_bank_a_x (
        .clk(clk), .i_we(w_we_A), .i_waddr(w_waddr_A), .i_wdata(w_wdata_A),
        .i_raddr(W_addr_B), .o_rdata(w_old_mem_B));
    ram_2w2r_xor_copy #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_bank_a_ra (
        .clk(clk), .i_we(w_we_A), .i_waddr(w_waddr_A), .i_wdata(w_wdata_A),
        .i_raddr(R_addr_A), .o_rdata(w_rd_A_bankA));
    ram_2w2r_xor_copy #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_bank_a_rb (
        .clk(clk), .i_we(w_we_A), .i_waddr(w_waddr_A), .i_wdata(w_wdata_A),
        .i_raddr(R_addr_B), .o_rdata(w_rd_B_bankA));

    // Bank B copies: lookup for writer A, read port A, read port B.
    ram_2w2r_xor_copy #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_bank_b_x (
        .clk(clk), .i_we(w_we_B), .i_waddr(w_waddr_B), .i_wdata(w_wdata_B),
        .i_raddr(W_addr_A), .o_rdata(w_old_mem_A));
    ram_2w2r_xor_copy #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_bank_b_ra (
        .clk(clk), .i_we(w_we_B), .i_waddr(w_waddr_B), .i_wdata(w_wdata_B),
        .i_raddr(R_addr_A), .o_rdata(w_rd_A_bankB));
    ram_2w2r_xor_copy #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_bank_b_rb (
        .clk(clk), .i_we(w_we_B), .i_waddr(w_waddr_B), .i_wdata(w_wdata_B),
        .i_raddr(R_addr_B), .o_rdata(w_rd_B_bankB));

    // ------------------------------------------------------------------
    //  Read path
    // ------------------------------------------------------------------

    // Newest-first search of writes not yet visible in the RAM copies:
    // this cycle's writes (A before B), then writes committing this cycle.
    function automatic logic [WIDTH:0] f_read_fwd(
        input logic [ADDR_W-1:0] raddr,
        input logic              s1a_en,
        input logic [ADDR_W-1:0] s1a_addr,
        input logic [WIDTH-1:0]  s1a_data,
        input logic              s1b_en,
        input logic [ADDR_W-1:0] s1b_addr,
        input logic [WIDTH-1:0]  s1b_data,
        input logic              s2a_en,
        input logic [ADDR_W-1:0] s2a_addr,
        input logic [WIDTH-1:0]  s2a_data,
        input logic              s2b_en,
        input logic [ADDR_W-1:0] s2b_addr,
        input logic [WIDTH-1:0]  s2b_data
    );
        logic [WIDTH:0] v_res;
        v_res = '0;
        if (s1a_en && (s1a_addr == raddr)) begin
            v_res = {1'b1, s1a_data};
        end else if (s1b_en && (s1b_addr == raddr)) begin
            v_res = {1'b1, s1b_data};
        end else if (s2a_en && (s2a_addr == raddr)) begin
            v_res = {1'b1, s2a_data};
        end else if (s2b_en && (s2b_addr == raddr)) begin
            v_res = {1'b1, s2b_data};
        end
        return v_res;
    endfunction

    logic [WIDTH:0]   w_fwd_A;
    logic [WIDTH:0]   w_fwd_B;
    logic             r_rv_A;
    logic             r_rv_B;
    logic             r_rfwd_hit_A;
    logic             r_rfwd_hit_B;
    logic [WIDTH-1:0] r_rfwd_val_A;
    logic [WIDTH-1:0] r_rfwd_val_B;
    logic [WIDTH-1:0] r_hold_A;
    logic [WIDTH-1:0] r_hold_B;
    logic [WIDTH-1:0] w_rdata_A;
    logic [WIDTH-1:0] w_rdata_B;

    // Logical value written by stage 2 is its write data, not the XOR'd bank word.
    assign w_fwd_A = f_read_fwd(R_addr_A,
                                w_wr_A, W_addr_A, W_data_A,
                                w_wr_B, W_addr_B, W_data_B,
                                w_cmt_en_A, r_s2_addr_A, r_s2_data_A,
                                w_cmt_en_B, r_s2_addr_B, r_s2_data_B);
    assign w_fwd_B = f_read_fwd(R_addr_B,
                                w_wr_A, W_addr_A, W_data_A,
                                w_wr_B, W_addr_B, W_data_B,
                                w_cmt_en_A, r_s2_addr_A, r_s2_data_A,
                                w_cmt_en_B, r_s2_addr_B, r_s2_data_B);

    // Read valid flags and last-data holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rv_A   <= 1'b0;
            r_rv_B   <= 1'b0;
            r_hold_A <= '0;
            r_hold_B <= '0;
        end else begin
            r_rv_A <= w_rd_A;
            r_rv_B <= w_rd_B;
            if (r_rv_A) begin
                r_hold_A <= w_rdata_A;
            end
            if (r_rv_B) begin
                r_hold_B <= w_rdata_B;
            end
        end
    end

    // Forwarding result captured alongside the RAM read.
    always_ff @(posedge clk) begin
        r_rfwd_hit_A <= w_fwd_A[WIDTH];
        r_rfwd_hit_B <= w_fwd_B[WIDTH];
        r_rfwd_val_A <= w_fwd_A[WIDTH-1:0];
        r_rfwd_val_B <= w_fwd_B[WIDTH-1:0];
    end

    assign w_rdata_A = r_rfwd_hit_A ? r_rfwd_val_A : (w_rd_A_bankA ^ w_rd_A_bankB);
    assign w_rdata_B = r_rfwd_hit_B ? r_rfwd_val_B : (w_rd_B_bankA ^ w_rd_B_bankB);

    assign R_valid_A = r_rv_A;
    assign R_valid_B = r_rv_B;
    assign R_data_A  = r_rv_A ? w_rdata_A : r_hold_A;
    assign R_data_B  = r_rv_B ? w_rdata_B : r_hold_B;
endmodule
`default_nettype wire
